alu_rf: RTL and testbench
=========================

# alu_rf

Parametrised bus-attached ALU with an NREGS-entry operand register file, selectable operands, a status-flag register and a multi-cycle shift-add multiplier. It sits on the shared tri-state data bus alongside memory and the control unit, and is driven each cycle by a control-unit micro-op. It is the generalised successor of the two-register bus ALU.

## Interface
- WIDTH, 8: data and bus width in bits; minimum 2.
- NREGS, 4: number of operand registers; a power of two, minimum 2.
- clock  in  1  system clock; all state updates on its rising edge.
- n_reset  in  1  reset; synchronous, active-low.
- op  in  alu_op_t  micro-op, sampled at the rising edge.
- sel_a  in  $clog2(NREGS)  operand/destination register index A.
- sel_b  in  $clog2(NREGS)  operand register index B.
- bus  inout  WIDTH  shared data bus; driven only while clock=1 and drive_en=1, otherwise Z.
- flags  out  4  {V,C,N,Z}, registered.
- busy  out  1  high while a multiply is in progress.

## Operation
- Ops:
  - NOP: drive nothing.
  - READ: bus<-r[a].
  - WRITE: r[a]<-bus.
  - ADD: bus<-r[a]+r[b].
  - ADC: bus<-r[a]+r[b]+C.
  - SUB: bus<-r[a]-r[b].
  - INC: bus<-r[a]+1.
  - AND, OR, XOR: bus<-r[a] op r[b].
  - SHL: bus<-r[a]<<1.
  - SHR: bus<-r[a]>>1, logical.
  - MUL: r[a]<-low WIDTH bits of r[a]*r[b], unsigned.
  - CLRF: flags<-0.
- Arithmetic is done at WIDTH+1 bits; the result is truncated to WIDTH.
- Flag updates:
  - ADD, ADC, INC: C = carry-out; V = signed overflow.
  - SUB: C = borrow, i.e. 1 when r[a]<r[b] unsigned; V = signed overflow.
  - Logic ops: C and V unchanged.
  - SHL, SHR: C = the bit shifted out; V unchanged.
  - MUL: Z and N set from the low result; C = 1 if the high half is nonzero; V unchanged.
  - Z and N are updated by every op that produces a result.
  - READ, WRITE and NOP leave the flags unchanged.
- sel_a == sel_b is legal:
  - ADD doubles the register.
  - SUB yields 0 with Z=1 and C=0.
  - MUL squares the register.
- Multiplier FSM:
  - States: IDLE -> RUN when MUL is sampled in IDLE.
  - On entry to RUN, operands are latched from r[a] and r[b], dest<-sel_a, and a counter is loaded with WIDTH.
  - Each RUN cycle does one shift-add step and decrements the counter.
  - RUN -> DONE when the counter reaches 0.
  - DONE writes r[dest] and flags, then returns to IDLE.
  - busy = 1 in RUN and DONE.
- While busy=1, every op except NOP is ignored with no side effects (no register writes, flags unchanged, no bus drive). The control unit must hold NOP or poll busy.
- Reset, including mid-multiply: on the next rising edge with n_reset=0, all r[i]<=0, flags<=0, drive_en<=0, FSM<=IDLE, counter<=0. Any partial product is discarded and r[dest] is not written.

## Timing
- A result op sampled at rising edge k registers its result and sets drive_en at edge k. The bus carries the result during the high phase of cycle k only.
- drive_en clears at edge k+1 unless the next op also drives.
- WRITE captures the bus value present at edge k. Flags update at edge k.
- MUL sampled at edge k:
  - busy=1 from edge k through edge k+WIDTH+1.
  - r[a] and flags update at edge k+WIDTH+1.
  - busy=0 and a new op is accepted at edge k+WIDTH+2.
- Reset values: bus=Z, flags=0, busy=0.

## Structure
- Shared package cuca_pkg holds:
  - the enum_alu_op list (NOP, READ, WRITE, ADD, ADC, SUB, INC, AND, OR, XOR, SHL, SHR, MUL, CLRF, ALU_MAX);
  - alu_op_t, sized $clog2(ALU_MAX);
  - flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- The existing tri_buf is instantiated for the bus drive.
- Natural sub-module: alu_mul_seq (multiplier FSM, counter and accumulator). Interface: start, a, b, busy, done, product[2*WIDTH-1:0].

## Test plan
- WIDTH=8: WRITE r0<-0x7F, WRITE r1<-0x01, ADD a=0 b=1 -> bus=0x80 in the high phase; flags N=1, V=1, C=0, Z=0.
- r2=0x05, r3=0x05, SUB a=2 b=3 -> bus=0x00, Z=1, C=0. Then SUB with r2=0x03 -> bus=0xFE, C=1, N=1.
- r0=0xFF, SHL a=0 -> bus=0xFE, C=1. Then ADC r0+r1 with r1=0x00 -> bus=0x00, C=1, Z=1.
- r0=0x0C, r1=0x0B, MUL a=0 b=1:
  - busy=1 for exactly 9 cycles, then r0=0x84, C=0.
  - A WRITE r1 issued mid-run is ignored, so r1 stays 0x0B.
- r0=0x10, r1=0x10, MUL with n_reset asserted 3 cycles in -> all registers 0, flags 0, busy=0 at the next edge, bus=Z.
- Bus contention check: NOP and WRITE cycles, and the low phase of every cycle -> bus=Z; bus is never driven by alu_rf while busy=1.

Source files
------------

// File: rtl/cuca_pkg.sv
// Shared control-unit/ALU definitions: micro-op codes, flag bit positions,
// multiplier state encoding and the op decoder.
package cuca_pkg;

   typedef enum int unsigned {
      NOP, READ, WRITE, ADD, ADC, SUB, INC, AND, OR, XOR, SHL, SHR, MUL, CLRF, ALU_MAX
   } enum_alu_op;

   localparam int unsigned ALU_OP_W = $clog2(ALU_MAX);

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_RUN,
      MUL_DONE
   } mul_state_t;

   // Unused op codes above CLRF behave as NOP.
   function automatic enum_alu_op decode_op(input alu_op_t code);
      if (32'(code) >= 32'(ALU_MAX)) return NOP;
      return enum_alu_op'(32'(code));
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier: one partial-product step per
// cycle, WIDTH steps, followed by a single DONE cycle.
module alu_mul_seq
   import cuca_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clock,
   input  logic               n_reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   mul_state_t         state, state_next;
   logic [CNT_W-1:0]   count, count_next;
   logic [WIDTH-1:0]   mcand, mcand_next;
   logic [2*WIDTH-1:0] acc, acc_next;
   logic [WIDTH:0]     partial;

   // State, counter and accumulator registers; reset discards any partial product.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state <= MUL_IDLE;
         count <= '0;
         mcand <= '0;
         acc   <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         mcand <= mcand_next;
         acc   <= acc_next;
      end
   end

   // Next-state logic; acc holds {high partial sum, remaining multiplier bits}.
   always_comb begin
      state_next = state;
      count_next = count;
      mcand_next = mcand;
      acc_next   = acc;
      busy       = 1'b0;
      done       = 1'b0;
      partial    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      case (state)
         MUL_IDLE: begin
            if (start) begin
               state_next = MUL_RUN;
               mcand_next = a;
               acc_next   = {{WIDTH{1'b0}}, b};
               count_next = CNT_W'(WIDTH);
            end
         end
         MUL_RUN: begin
            busy       = 1'b1;
            acc_next   = {partial, acc[WIDTH-1:1]};
            count_next = count - CNT_W'(1);
            if (count == CNT_W'(1)) state_next = MUL_DONE;
         end
         MUL_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = MUL_IDLE;
         end
         default: state_next = MUL_IDLE;
      endcase
   end

   assign product = acc;

endmodule

// File: rtl/tri_buf.sv
// Tri-state driver onto the shared data bus.
module tri_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output wire  [WIDTH-1:0] y
);

   assign y = en ? d : 'z;

endmodule

// File: rtl/alu_rf.sv
// Bus-attached ALU with an NREGS-entry operand register file, status flags
// and a sequential multiplier. Results are driven onto the shared bus only
// during the high phase of the cycle following the sampling edge.
module alu_rf
   import cuca_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 4
) (
   input  logic                       clock,
   input  logic                       n_reset,
   input  alu_op_t                    op,
   input  logic [$clog2(NREGS)-1:0]   sel_a,
   input  logic [$clog2(NREGS)-1:0]   sel_b,
   inout  wire  [WIDTH-1:0]           bus,
   output logic [3:0]                 flags,
   output logic                       busy
);

   localparam int unsigned SEL_W = $clog2(NREGS);

   logic [WIDTH-1:0]   regs [NREGS];
   logic [WIDTH-1:0]   result;
   logic               drive_en;
   logic               bus_en;
   logic [SEL_W-1:0]   dest;

   enum_alu_op         op_e;
   logic [WIDTH-1:0]   opa, opb;
   logic [WIDTH:0]     wide;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_drive;
   logic               set_zn;
   logic [3:0]         alu_flags;
   logic [3:0]         mul_flags;

   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] product;

   assign op_e      = decode_op(op);
   assign opa       = regs[sel_a];
   assign opb       = regs[sel_b];
   assign mul_start = !mul_busy && (op_e == MUL);
   assign busy      = mul_busy;
   assign bus_en    = clock & drive_en;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clock   (clock),
      .n_reset (n_reset),
      .start   (mul_start),
      .a       (opa),
      .b       (opb),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   tri_buf #(.WIDTH(WIDTH)) u_bus (
      .en (bus_en),
      .d  (result),
      .y  (bus)
   );

   // Single-cycle ALU result, bus-drive request and updated flags for the sampled op.
   always_comb begin
      wide      = '0;
      alu_res   = '0;
      alu_drive = 1'b0;
      set_zn    = 1'b0;
      alu_flags = flags;
      case (op_e)
         READ: begin
            alu_res   = opa;
            alu_drive = 1'b1;
         end
         ADD, ADC: begin
            wide = {1'b0, opa} + {1'b0, opb}
                 + ((op_e == ADC) ? (WIDTH+1)'(flags[FLAG_C]) : '0);
            alu_res           = wide[WIDTH-1:0];
            alu_flags[FLAG_C] = wide[WIDTH];
            alu_flags[FLAG_V] = (opa[WIDTH-1] == opb[WIDTH-1]) && (wide[WIDTH-1] != opa[WIDTH-1]);
            alu_drive         = 1'b1;
            set_zn            = 1'b1;
         end
         SUB: begin
            wide              = {1'b0, opa} - {1'b0, opb};
            alu_res           = wide[WIDTH-1:0];
            alu_flags[FLAG_C] = wide[WIDTH];
            alu_flags[FLAG_V] = (opa[WIDTH-1] != opb[WIDTH-1]) && (wide[WIDTH-1] != opa[WIDTH-1]);
            alu_drive         = 1'b1;
            set_zn            = 1'b1;
         end
         INC: begin
            wide              = {1'b0, opa} + (WIDTH+1)'(1);
            alu_res           = wide[WIDTH-1:0];
            alu_flags[FLAG_C] = wide[WIDTH];
            alu_flags[FLAG_V] = !opa[WIDTH-1] && wide[WIDTH-1];
            alu_drive         = 1'b1;
            set_zn            = 1'b1;
         end
         AND, OR, XOR: begin
            alu_res   = (op_e == AND) ? (opa & opb) :
                        (op_e == OR)  ? (opa | opb) : (opa ^ opb);
            alu_drive = 1'b1;
            set_zn    = 1'b1;
         end
         SHL: begin
            alu_res           = {opa[WIDTH-2:0], 1'b0};
            alu_flags[FLAG_C] = opa[WIDTH-1];
            alu_drive         = 1'b1;
            set_zn            = 1'b1;
         end
         SHR: begin
            alu_res           = {1'b0, opa[WIDTH-1:1]};
            alu_flags[FLAG_C] = opa[0];
            alu_drive         = 1'b1;
            set_zn            = 1'b1;
         end
         CLRF: alu_flags = '0;
         default: ;
      endcase
      if (set_zn) begin
         alu_flags[FLAG_Z] = (alu_res == '0);
         alu_flags[FLAG_N] = alu_res[WIDTH-1];
      end
   end

   // Flags produced when the multiplier retires; V is left untouched.
   always_comb begin
      mul_flags         = flags;
      mul_flags[FLAG_Z] = (product[WIDTH-1:0] == '0);
      mul_flags[FLAG_N] = product[WIDTH-1];
      mul_flags[FLAG_C] = (product[2*WIDTH-1:WIDTH] != '0);
   end

   // Register file, flags and bus-drive state; all ops are ignored while the multiplier runs.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
         flags    <= '0;
         drive_en <= 1'b0;
         result   <= '0;
         dest     <= '0;
      end else begin
         drive_en <= 1'b0;
         if (mul_done) begin
            regs[dest] <= product[WIDTH-1:0];
            flags      <= mul_flags;
         end else if (!mul_busy) begin
            if (op_e == WRITE) regs[sel_a] <= bus;
            if (mul_start) dest <= sel_a;
            flags    <= alu_flags;
            drive_en <= alu_drive;
            if (alu_drive) result <= alu_res;
         end
      end
   end

endmodule

// File: tb/tb_alu_rf.sv
// Self-checking bench for alu_rf (WIDTH=8, NREGS=4): directed vector table,
// multiplier corner sequences, then randomized ops against a reference model.
module tb_alu_rf;
   import cuca_pkg::*;

   localparam int W = 8;

   logic       clock;
   logic       n_reset;
   alu_op_t    op;
   logic [1:0] sel_a, sel_b;
   logic [3:0] flags;
   logic       busy;
   logic       tb_en;
   logic [7:0] tb_val;
   wire  [7:0] bus;
   wire        oe;

   assign bus = tb_en ? tb_val : 'z;
   assign oe  = dut.bus_en;

   alu_rf #(.WIDTH(8), .NREGS(4)) dut (
      .clock   (clock),
      .n_reset (n_reset),
      .op      (op),
      .sel_a   (sel_a),
      .sel_b   (sel_b),
      .bus     (bus),
      .flags   (flags),
      .busy    (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;

   typedef struct {
      enum_alu_op o;
      int         a;
      int         b;
      int         wv;
      int         exp_bus;
      bit         exp_drv;
      logic [3:0] exp_f;
   } vec_t;

   vec_t tbl[$];

   // reference model state
   int         m_r [4];
   logic [3:0] m_f;
   int         m_busy;
   int         m_dest;
   int         m_prod;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One bus cycle: check the low phase is undriven, apply inputs, sample in the high phase.
   task automatic step(input enum_alu_op o, input int a, input int b, input int wv);
      @(negedge clock);
      #1;
      check("low_phase_z", oe, 0);
      op    = alu_op_t'(o);
      sel_a = a[1:0];
      sel_b = b[1:0];
      if (o == WRITE) begin
         tb_en  = 1'b1;
         tb_val = wv[7:0];
      end
      @(posedge clock);
      #1;
      tb_en = 1'b0;
   endtask

   function automatic int sv(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   task automatic set_zn(input int res);
      m_f[FLAG_Z] = (res == 0);
      m_f[FLAG_N] = (res >= 128);
   endtask

   task automatic model_op(input enum_alu_op o, input int a, input int b, input int wv,
                           output int res, output bit drv);
      int x, y, t, st, cin;
      x   = m_r[a];
      y   = m_r[b];
      cin = m_f[FLAG_C] ? 1 : 0;
      res = 0;
      drv = 1'b0;
      case (o)
         READ:  begin res = x; drv = 1'b1; end
         WRITE: m_r[a] = wv;
         ADD, ADC: begin
            t  = x + y + ((o == ADC) ? cin : 0);
            st = sv(x) + sv(y) + ((o == ADC) ? cin : 0);
            res = t % 256;
            m_f[FLAG_C] = (t >= 256);
            m_f[FLAG_V] = (st > 127) || (st < -128);
            set_zn(res); drv = 1'b1;
         end
         SUB: begin
            t  = x - y;
            st = sv(x) - sv(y);
            res = (t + 256) % 256;
            m_f[FLAG_C] = (x < y);
            m_f[FLAG_V] = (st > 127) || (st < -128);
            set_zn(res); drv = 1'b1;
         end
         INC: begin
            t  = x + 1;
            st = sv(x) + 1;
            res = t % 256;
            m_f[FLAG_C] = (t >= 256);
            m_f[FLAG_V] = (st > 127);
            set_zn(res); drv = 1'b1;
         end
         AND: begin res = x & y; set_zn(res); drv = 1'b1; end
         OR:  begin res = x | y; set_zn(res); drv = 1'b1; end
         XOR: begin res = x ^ y; set_zn(res); drv = 1'b1; end
         SHL: begin res = (x * 2) % 256; m_f[FLAG_C] = (x >= 128); set_zn(res); drv = 1'b1; end
         SHR: begin res = x / 2; m_f[FLAG_C] = (x % 2 == 1); set_zn(res); drv = 1'b1; end
         MUL: begin m_prod = x * y; m_dest = a; m_busy = W + 1; end
         CLRF: m_f = '0;
         default: ;
      endcase
   endtask

   initial begin
      int busy_cycles;
      bit prev_drv;

      tb_en   = 1'b0;
      tb_val  = '0;
      op      = alu_op_t'(NOP);
      sel_a   = '0;
      sel_b   = '0;
      n_reset = 1'b0;

      // ---------------- reset state
      step(NOP, 0, 0, 0);
      step(NOP, 0, 0, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", flags, 4'h0);
      check("rst_bus_z", oe, 0);
      n_reset = 1'b1;

      // ---------------- directed vectors; flags are {V,C,N,Z}
      tbl.push_back('{WRITE, 0, 0, 'h7F, 0,    1'b0, 4'b0000});
      tbl.push_back('{WRITE, 1, 0, 'h01, 0,    1'b0, 4'b0000});
      tbl.push_back('{ADD,   0, 1, 0,    'h80, 1'b1, 4'b1010});
      tbl.push_back('{NOP,   0, 0, 0,    0,    1'b0, 4'b1010});
      tbl.push_back('{WRITE, 2, 0, 'h05, 0,    1'b0, 4'b1010});
      tbl.push_back('{WRITE, 3, 0, 'h05, 0,    1'b0, 4'b1010});
      tbl.push_back('{SUB,   2, 3, 0,    'h00, 1'b1, 4'b0001});
      tbl.push_back('{NOP,   0, 0, 0,    0,    1'b0, 4'b0001});
      tbl.push_back('{WRITE, 2, 0, 'h03, 0,    1'b0, 4'b0001});
      tbl.push_back('{SUB,   2, 3, 0,    'hFE, 1'b1, 4'b0110});
      tbl.push_back('{NOP,   0, 0, 0,    0,    1'b0, 4'b0110});
      tbl.push_back('{WRITE, 0, 0, 'hFF, 0,    1'b0, 4'b0110});
      tbl.push_back('{SHL,   0, 0, 0,    'hFE, 1'b1, 4'b0110});
      tbl.push_back('{NOP,   0, 0, 0,    0,    1'b0, 4'b0110});
      tbl.push_back('{WRITE, 1, 0, 'h00, 0,    1'b0, 4'b0110});
      tbl.push_back('{ADC,   0, 1, 0,    'h00, 1'b1, 4'b0101});
      tbl.push_back('{CLRF,  0, 0, 0,    0,    1'b0, 4'b0000});
      tbl.push_back('{READ,  0, 0, 0,    'hFF, 1'b1, 4'b0000});
      tbl.push_back('{ADD,   0, 0, 0,    'hFE, 1'b1, 4'b0110});
      tbl.push_back('{SHR,   0, 0, 0,    'h7F, 1'b1, 4'b0100});
      tbl.push_back('{INC,   0, 0, 0,    'h00, 1'b1, 4'b0101});
      tbl.push_back('{XOR,   0, 0, 0,    'h00, 1'b1, 4'b0101});
      tbl.push_back('{AND,   0, 2, 0,    'h03, 1'b1, 4'b0100});
      tbl.push_back('{OR,    1, 2, 0,    'h03, 1'b1, 4'b0100});
      tbl.push_back('{SUB,   0, 0, 0,    'h00, 1'b1, 4'b0001});
      tbl.push_back('{NOP,   0, 0, 0,    0,    1'b0, 4'b0001});
      tbl.push_back('{WRITE, 3, 0, 'h7F, 0,    1'b0, 4'b0001});
      tbl.push_back('{INC,   3, 0, 0,    'h80, 1'b1, 4'b1010});
      tbl.push_back('{NOP,   0, 0, 0,    0,    1'b0, 4'b1010});
      tbl.push_back('{WRITE, 2, 0, 'h80, 0,    1'b0, 4'b1010});
      tbl.push_back('{SUB,   2, 3, 0,    'h01, 1'b1, 4'b1000});
      tbl.push_back('{NOP,   0, 0, 0,    0,    1'b0, 4'b1000});

      foreach (tbl[i]) begin
         step(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].wv);
         check($sformatf("vec%0d_drive", i), oe, tbl[i].exp_drv);
         if (tbl[i].exp_drv) check($sformatf("vec%0d_bus", i), bus, tbl[i].exp_bus);
         check($sformatf("vec%0d_flags", i), flags, tbl[i].exp_f);
         check($sformatf("vec%0d_busy", i), busy, 0);
      end

      // ---------------- multiply 0x0C * 0x0B with ignored ops mid-run
      step(WRITE, 0, 0, 'h0C);
      step(WRITE, 1, 0, 'h0B);
      step(MUL, 0, 1, 0);
      check("mul_start_drive", oe, 0);
      busy_cycles = busy ? 1 : 0;
      for (int j = 1; j < 40 && busy; j++) begin
         if (j == 3)      step(WRITE, 1, 0, 'h55);
         else if (j == 5) step(READ, 0, 0, 0);
         else if (j == 6) step(CLRF, 0, 0, 0);
         else             step(NOP, 0, 0, 0);
         check("mul_busy_no_drive", oe, 0);
         if (busy) busy_cycles++;
      end
      check("mul_busy_cycles", busy_cycles, 9);
      check("mul_busy_end", busy, 0);
      check("mul_flags", flags, 4'b1010);
      step(READ, 0, 0, 0);
      check("mul_r0", bus, 'h84);
      step(READ, 1, 0, 0);
      check("mul_r1_kept", bus, 'h0B);

      // ---------------- reset three cycles into a multiply
      step(NOP, 0, 0, 0);
      step(WRITE, 0, 0, 'h10);
      step(WRITE, 1, 0, 'h10);
      step(MUL, 0, 1, 0);
      step(NOP, 0, 0, 0);
      step(NOP, 0, 0, 0);
      n_reset = 1'b0;
      step(NOP, 0, 0, 0);
      check("mrst_busy", busy, 0);
      check("mrst_flags", flags, 4'h0);
      check("mrst_bus_z", oe, 0);
      n_reset = 1'b1;
      for (int j = 0; j < 10; j++) step(NOP, 0, 0, 0);
      for (int r = 0; r < 4; r++) begin
         step(READ, r, 0, 0);
         check($sformatf("mrst_r%0d", r), bus, 0);
      end
      check("mrst_flags_late", flags, 4'h0);

      // ---------------- randomized ops against the reference model
      foreach (m_r[i]) m_r[i] = 0;
      m_f      = '0;
      m_busy   = 0;
      m_dest   = 0;
      m_prod   = 0;
      prev_drv = 1'b1;
      for (int n = 0; n < 400; n++) begin
         enum_alu_op o;
         int a, b, wv, res;
         bit drv;
         o = enum_alu_op'($urandom_range(0, 13));
         if (o == MUL && $urandom_range(0, 3) != 0) o = ADD;
         if (o == WRITE && prev_drv) o = NOP;
         a  = $urandom_range(0, 3);
         b  = $urandom_range(0, 3);
         wv = $urandom_range(0, 255);
         step(o, a, b, wv);
         res = 0;
         drv = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_r[m_dest] = m_prod % 256;
               set_zn(m_prod % 256);
               m_f[FLAG_C] = (m_prod >= 256);
            end
         end else begin
            model_op(o, a, b, wv, res, drv);
         end
         check($sformatf("rnd%0d_drive", n), oe, drv);
         if (drv) check($sformatf("rnd%0d_bus", n), bus, res);
         check($sformatf("rnd%0d_flags", n), flags, m_f);
         check($sformatf("rnd%0d_busy", n), busy, (m_busy > 0));
         prev_drv = drv;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
